// File: rtl/inst_encoder_loader_if.sv
// rtl/inst_encoder_loader_if.sv - field stream in, imem write port out
interface inst_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_fn;
    logic [1:0]        in_rs1;
    logic [1:0]        in_rs2;
    logic [3:0]        in_imm;
    logic              imem_stall;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;

    modport master (
        output in_valid, in_fn, in_rs1, in_rs2, in_imm, imem_stall,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_fn, in_rs1, in_rs2, in_imm, imem_stall,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - packs decoded fields into 8-bit words and loads imem
module inst_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   length_i,
    inst_encoder_loader_if.slave bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  err_count_o
);
    typedef enum logic {IDLE, LOAD} state_t;

    localparam logic [ADDR_W:0]   REM_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [2:0] opc;
    logic [7:0] enc_word;
    logic       enc_legal;
    logic       commit;
    logic       accept;

    always_comb begin
        opc       = bus.in_fn[2:0];
        enc_legal = 1'b1;
        enc_word  = {bus.in_rs2[0], bus.in_rs1[0], bus.in_rs2[1], bus.in_rs1[1], bus.in_fn};
        case (opc)
            3'b001, 3'b101, 3'b110: begin
                enc_word  = {bus.in_rs2[0], bus.in_rs1[0], bus.in_imm[2:0], opc};
                enc_legal = !(bus.in_rs1[1] | bus.in_rs2[1] | bus.in_imm[3]);
            end
            3'b010: begin
                enc_word  = {bus.in_rs1[0], bus.in_imm, opc};
                enc_legal = !bus.in_rs1[1];
            end
            3'b111: begin
                if (bus.in_fn[3]) begin
                    enc_word = {bus.in_imm, 1'b1, 3'b111};
                end
            end
            default: ;
        endcase
    end

    // Ready depends only on registered state and stall so a source may wait on it.
    assign commit       = we_q & !bus.imem_stall;
    assign bus.in_ready = (state_q == LOAD) && (remaining_q != '0) && (!we_q || !bus.imem_stall);
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (length_i != '0) begin
                        state_d     = LOAD;
                        remaining_d = length_i;
                        addr_d      = base_addr_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (commit) begin
                    we_d   = 1'b0;
                    addr_d = addr_q + ADDR_ONE;
                end
                if (accept) begin
                    remaining_d = remaining_q - REM_ONE;
                    if (enc_legal) begin
                        we_d    = 1'b1;
                        wdata_d = enc_word;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_ONE;
                        end
                    end
                end
                // Leave on the cycle the last write commits so done lines up with busy falling.
                if (remaining_d == '0 && !we_d) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign err_count_o    = err_cnt_q;
endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb/tb_inst_encoder_loader.sv - directed self-checking bench for inst_encoder_loader
module tb_inst_encoder_loader;
    logic       clk;
    logic       rst;
    logic       start_i;
    logic [7:0] base_addr_i;
    logic [8:0] length_i;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [7:0] err_count_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] log_addr[$];
    logic [7:0] log_data[$];
    int         log_cyc[$];
    int         err_pulses = 0;

    inst_encoder_loader_if #(.ADDR_W(8)) bus();

    inst_encoder_loader #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .length_i    (length_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_count_o (err_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.imem_we && !bus.imem_stall) begin
            log_addr.push_back(bus.imem_addr);
            log_data.push_back(bus.imem_wdata);
            log_cyc.push_back(cyc);
        end
        if (!rst && err_o) err_pulses <= err_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_session(input logic [7:0] base, input logic [8:0] len);
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = base;
        length_i    = len;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input string tag, input logic [3:0] fn, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [3:0] imm);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_fn    = fn;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        #1;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) chk({tag, "_ready_timeout"}, 32'(n), 32'(0));
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done_o, 1'b1);
        chk({tag, "_busy_low"}, busy_o, 1'b0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic expect_writes(input string tag, input int n,
                                 input logic [7:0] ea[5], input logic [7:0] ed[5],
                                 input logic back_to_back);
        int m;
        chk({tag, "_nwrites"}, 32'(log_data.size()), 32'(n));
        m = (log_data.size() < n) ? log_data.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), log_addr[i], ea[i]);
            chk($sformatf("%s_data%0d", tag, i), log_data[i], ed[i]);
            if (back_to_back && i > 0)
                chk($sformatf("%s_gap%0d", tag, i), 32'(log_cyc[i] - log_cyc[i-1]), 32'(1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_we"}, bus.imem_we, 1'b0);
        chk({tag, "_addr"}, bus.imem_addr, 8'h00);
        chk({tag, "_wdata"}, bus.imem_wdata, 8'h00);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_err"}, err_o, 1'b0);
        chk({tag, "_errcnt"}, err_count_o, 8'h00);
    endtask

    logic [7:0] ea[5];
    logic [7:0] ed[5];

    initial begin
        rst            = 1'b1;
        start_i        = 1'b0;
        base_addr_i    = '0;
        length_i       = '0;
        bus.in_valid   = 1'b0;
        bus.in_fn      = '0;
        bus.in_rs1     = '0;
        bus.in_rs2     = '0;
        bus.in_imm     = '0;
        bus.imem_stall = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // single ADD
        clear_log();
        start_session(8'h10, 9'd1);
        chk("single_busy", busy_o, 1'b1);
        send("single", 4'b0011, 2'b10, 2'b01, 4'b0000);
        bus.in_valid = 1'b0;
        chk("single_we", bus.imem_we, 1'b1);
        chk("single_addr", bus.imem_addr, 8'h10);
        chk("single_wdata", bus.imem_wdata, 8'h93);
        @(negedge clk);
        chk("single_done", done_o, 1'b1);
        chk("single_busy_low", busy_o, 1'b0);
        chk("single_nwrites", 32'(log_data.size()), 32'(1));

        // five-beat burst
        clear_log();
        start_session(8'h10, 9'd5);
        send("burst", 4'b0010, 2'b01, 2'b11, 4'b0101);
        send("burst", 4'b1111, 2'b11, 2'b10, 4'b0110);
        send("burst", 4'b1101, 2'b01, 2'b00, 4'b0011);
        send("burst", 4'b0111, 2'b01, 2'b11, 4'b0000);
        send("burst", 4'b0011, 2'b10, 2'b01, 4'b0000);
        bus.in_valid = 1'b0;
        wait_done("burst");
        ea = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        ed = '{8'hAA, 8'h6F, 8'h5D, 8'hE7, 8'h93};
        expect_writes("burst", 5, ea, ed, 1'b1);

        // stall for three cycles with a write pending
        clear_log();
        start_session(8'h20, 9'd3);
        send("stall", 4'b0011, 2'b10, 2'b01, 4'b0000);
        bus.imem_stall = 1'b1;
        bus.in_fn      = 4'b1111;
        bus.in_imm     = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall_ready%0d", i), bus.in_ready, 1'b0);
            chk($sformatf("stall_we%0d", i), bus.imem_we, 1'b1);
            chk($sformatf("stall_addr%0d", i), bus.imem_addr, 8'h20);
            chk($sformatf("stall_wdata%0d", i), bus.imem_wdata, 8'h93);
            @(negedge clk);
        end
        bus.imem_stall = 1'b0;
        send("stall", 4'b1111, 2'b00, 2'b00, 4'b0110);
        send("stall", 4'b0010, 2'b01, 2'b00, 4'b0101);
        bus.in_valid = 1'b0;
        wait_done("stall");
        ea = '{8'h20, 8'h21, 8'h22, 8'h00, 8'h00};
        ed = '{8'h93, 8'h6F, 8'hAA, 8'h00, 8'h00};
        expect_writes("stall", 3, ea, ed, 1'b0);

        // illegal store in the middle
        clear_log();
        err_pulses = 0;
        start_session(8'h30, 9'd3);
        send("illegal", 4'b0011, 2'b10, 2'b01, 4'b0000);
        send("illegal", 4'b0110, 2'b10, 2'b00, 4'b0001);
        chk("illegal_err_pulse", err_o, 1'b1);
        chk("illegal_errcnt", err_count_o, 8'h01);
        send("illegal", 4'b1111, 2'b00, 2'b00, 4'b0110);
        bus.in_valid = 1'b0;
        wait_done("illegal");
        chk("illegal_err_pulses", 32'(err_pulses), 32'(1));
        ea = '{8'h30, 8'h31, 8'h00, 8'h00, 8'h00};
        ed = '{8'h93, 8'h6F, 8'h00, 8'h00, 8'h00};
        expect_writes("illegal", 2, ea, ed, 1'b0);

        // address wrap, legal store and branch; start during LOAD ignored
        clear_log();
        start_session(8'hFF, 9'd2);
        start_i     = 1'b1;
        base_addr_i = 8'h40;
        length_i    = 9'd0;
        @(negedge clk);
        start_i = 1'b0;
        chk("ignore_start_done", done_o, 1'b0);
        chk("ignore_start_busy", busy_o, 1'b1);
        send("wrap", 4'b1110, 2'b01, 2'b01, 4'b0101);
        send("wrap", 4'b0001, 2'b00, 2'b00, 4'b0111);
        bus.in_valid = 1'b0;
        wait_done("wrap");
        ea = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        ed = '{8'hEE, 8'h39, 8'h00, 8'h00, 8'h00};
        expect_writes("wrap", 2, ea, ed, 1'b1);

        // zero length
        start_session(8'h55, 9'd0);
        chk("zero_done", done_o, 1'b1);
        chk("zero_busy", busy_o, 1'b0);
        @(negedge clk);
        chk("zero_done_once", done_o, 1'b0);
        chk("zero_busy_after", busy_o, 1'b0);

        // reset mid-session, then a clean session
        start_session(8'h50, 9'd4);
        send("midrst", 4'b0011, 2'b10, 2'b01, 4'b0000);
        send("midrst", 4'b0111, 2'b01, 2'b11, 4'b0000);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        start_session(8'h60, 9'd1);
        send("after_rst", 4'b1111, 2'b00, 2'b00, 4'b0011);
        bus.in_valid = 1'b0;
        wait_done("after_rst");
        ea = '{8'h60, 8'h00, 8'h00, 8'h00, 8'h00};
        ed = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_writes("after_rst", 1, ea, ed, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
